// File: rtl/merge_ni.sv
// merge_ni: N-input channel-concatenation buffer for the CNN merge stage.
//
// Each of the N_IN producer streams fills its own bank with one D x D x C
// feature map (T words). Once every bank is full, the banks are drained
// back-to-back in input order on a single ready/valid output. The output
// word sits in a register, so a memory read takes one cycle to reach it.
//
// Optional feature (macro MERGE_OVERLAP_EN):
//   When defined, a bank is released for refill as soon as its last word is
//   accepted at the output, so the next frame can be collected during DRAIN.
//   When undefined, no input is accepted until DRAIN finishes.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   per-input word valid
//   in_data    packed input words, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   per-input accept
//   out_valid  output word valid
//   out_data   output word
//   out_ready  downstream accept
//   out_last   high with the final word of a frame
//   out_src    bank index of the current out_data
//   busy       high while draining
module merge_ni #(
  parameter int N_IN       = 3,
  parameter int D          = 8,
  parameter int C          = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [N_IN-1:0]                          in_valid,
  input  logic [N_IN*DATA_WIDTH-1:0]               in_data,
  output logic [N_IN-1:0]                          in_ready,
  output logic                                     out_valid,
  output logic [DATA_WIDTH-1:0]                    out_data,
  input  logic                                     out_ready,
  output logic                                     out_last,
  output logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] out_src,
  output logic                                     busy
);

  localparam int T  = D * D * C;
  localparam int WW = (T > 1) ? $clog2(T) : 1;
  localparam int SW = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [N_IN-1:0]         full_q, full_d;
  logic [WW-1:0]           wcnt_q [N_IN];
  logic [WW-1:0]           wcnt_d [N_IN];
  logic [SW-1:0]           rbank_q, rbank_d;
  logic [WW-1:0]           roff_q, roff_d;
  logic                    rd_done_q, rd_done_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]           out_src_q, out_src_d;
  logic                    bank_end_q, bank_end_d;

  logic [DATA_WIDTH-1:0]   mem [N_IN][T];

  logic [N_IN-1:0]         accept;
  logic                    load;
  logic                    out_fire;

`ifdef MERGE_OVERLAP_EN
  assign in_ready = ~full_q;
`else
  assign in_ready = (state_q == COLLECT) ? ~full_q : '0;
`endif

  assign accept    = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  // The output register is refilled whenever it is empty or being consumed,
  // which gives one word per cycle without out_valid looking at out_ready.
  assign load      = (state_q == DRAIN) & ~rd_done_q & (~out_valid_q | out_ready);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = bank_end_q & (out_src_q == SW'(N_IN - 1));
  assign busy      = (state_q == DRAIN);

  // Bank storage has no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (accept[i]) begin
        mem[i][wcnt_q[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wcnt_d      = wcnt_q;
    rbank_d     = rbank_q;
    roff_d      = roff_q;
    rd_done_d   = rd_done_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    bank_end_d  = bank_end_q;

    for (int i = 0; i < N_IN; i++) begin
      if (accept[i]) begin
        if (wcnt_q[i] == WW'(T - 1)) begin
          wcnt_d[i] = '0;
          full_d[i] = 1'b1;
        end else begin
          wcnt_d[i] = wcnt_q[i] + 1'b1;
        end
      end
    end

`ifdef MERGE_OVERLAP_EN
    // A bank whose last word has left the output can take new data at once.
    if (out_fire && bank_end_q) begin
      full_d[out_src_q] = 1'b0;
    end
`endif

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem[rbank_q][roff_q];
      out_src_d   = rbank_q;
      bank_end_d  = (roff_q == WW'(T - 1));
      if (roff_q == WW'(T - 1)) begin
        roff_d = '0;
        if (rbank_q == SW'(N_IN - 1)) begin
          rd_done_d = 1'b1;
        end else begin
          rbank_d = rbank_q + 1'b1;
        end
      end else begin
        roff_d = roff_q + 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      bank_end_d  = 1'b0;
    end

    unique case (state_q)
      COLLECT: begin
        if (&full_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire && out_last) begin
          rbank_d   = '0;
          roff_d    = '0;
          rd_done_d = 1'b0;
`ifdef MERGE_OVERLAP_EN
          state_d   = (&full_d) ? DRAIN : COLLECT;
`else
          state_d   = COLLECT;
          full_d    = '0;
`endif
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= COLLECT;
      full_q      <= '0;
      for (int i = 0; i < N_IN; i++) begin
        wcnt_q[i] <= '0;
      end
      rbank_q     <= '0;
      roff_q      <= '0;
      rd_done_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      bank_end_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wcnt_q      <= wcnt_d;
      rbank_q     <= rbank_d;
      roff_q      <= roff_d;
      rd_done_q   <= rd_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      bank_end_q  <= bank_end_d;
    end
  end

endmodule

// File: tb/tb_merge_ni.sv
// tb_merge_ni: directed testbench for merge_ni.
// Main instance: N_IN=3, D=2, C=1 (T=4). Corner instance: N_IN=2, D=1, C=1.
module tb_merge_ni;

  logic        clk;
  logic        reset_n;

  logic [2:0]  in_valid;
  logic [95:0] in_data;
  logic [2:0]  in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  out_src;
  logic        busy;

  logic [1:0]  in_valid2;
  logic [63:0] in_data2;
  logic [1:0]  in_ready2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic        out_ready2;
  logic        out_last2;
  logic [0:0]  out_src2;
  logic        busy2;

  int n_cmp = 0;
  int n_bad = 0;

  merge_ni #(.N_IN(3), .D(2), .C(1), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .out_src(out_src), .busy(busy)
  );

  merge_ni #(.N_IN(2), .D(1), .C(1), .DATA_WIDTH(32)) dut_corner (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
    .out_last(out_last2), .out_src(out_src2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pushes one 4-word frame on all inputs concurrently; word k of input i is
  // base + 16*i + k. Returns at the negedge after the final accept.
  task automatic fill_frame(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 3'b111;
      for (int i = 0; i < 3; i++) in_data[i*32 +: 32] = base + 32'(16*i + k);
    end
    @(negedge clk);
    in_valid = 3'b000;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
    n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_out_src: got %0d expected 0", out_src); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 3'b111) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b expected 111", in_ready); end
    n_cmp++; if (in_ready2 !== 2'b11) begin n_bad++; $display("[TB] FAIL reset_in_ready2: got %b expected 11", in_ready2); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 3'b111) begin n_bad++; $display("[TB] FAIL post_reset_in_ready: got %b expected 111", in_ready); end
  endtask

  task automatic test_fill;
    logic [31:0] exp;
    out_ready = 1'b1;
    fill_frame(32'h0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL fill_early_valid0: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 3'b000) begin n_bad++; $display("[TB] FAIL fill_in_ready_full: got %b expected 000", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL fill_early_valid1: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL fill_busy: got %b expected 1", busy); end
    @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      exp = 32'(16*(j/4) + j%4);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL fill_valid beat %0d: got %b expected 1", j, out_valid); end
      n_cmp++; if (out_data !== exp) begin n_bad++; $display("[TB] FAIL fill_data beat %0d: got %h expected %h", j, out_data, exp); end
      n_cmp++; if (out_src !== 2'(j/4)) begin n_bad++; $display("[TB] FAIL fill_src beat %0d: got %0d expected %0d", j, out_src, j/4); end
      n_cmp++; if (out_last !== (j == 11)) begin n_bad++; $display("[TB] FAIL fill_last beat %0d: got %b expected %b", j, out_last, (j == 11)); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL fill_end_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL fill_end_busy: got %b expected 0", busy); end
    n_cmp++; if (in_ready !== 3'b111) begin n_bad++; $display("[TB] FAIL fill_end_in_ready: got %b expected 111", in_ready); end
  endtask

  task automatic test_corner;
    @(negedge clk);
    in_valid2 = 2'b11;
    in_data2  = {32'd9, 32'd7};
    @(negedge clk);
    in_valid2 = 2'b00;
    in_data2  = {32'hBAD, 32'hBAD};
    n_cmp++; if (out_valid2 !== 1'b0) begin n_bad++; $display("[TB] FAIL corner_valid_early0: got %b expected 0", out_valid2); end
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b0) begin n_bad++; $display("[TB] FAIL corner_valid_early1: got %b expected 0", out_valid2); end
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b1 || out_data2 !== 32'd7 || out_src2 !== 1'b0 || out_last2 !== 1'b0) begin
      n_bad++; $display("[TB] FAIL corner_beat0: got v=%b d=%0d s=%0d l=%b expected v=1 d=7 s=0 l=0", out_valid2, out_data2, out_src2, out_last2);
    end
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b1 || out_data2 !== 32'd9 || out_src2 !== 1'b1 || out_last2 !== 1'b1) begin
      n_bad++; $display("[TB] FAIL corner_beat1: got v=%b d=%0d s=%0d l=%b expected v=1 d=9 s=1 l=1", out_valid2, out_data2, out_src2, out_last2);
    end
    @(negedge clk);
    n_cmp++; if (out_valid2 !== 1'b0 || in_ready2 !== 2'b11) begin
      n_bad++; $display("[TB] FAIL corner_end: got v=%b rdy=%b expected v=0 rdy=11", out_valid2, in_ready2);
    end
  endtask

  task automatic test_staggered;
    logic [31:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stagger_no_valid cycle %0d: got %b expected 0", c, out_valid); end
      if (c >= 4) begin
        n_cmp++; if (in_ready[1:0] !== 2'b00) begin n_bad++; $display("[TB] FAIL stagger_ready01 cycle %0d: got %b expected 00", c, in_ready[1:0]); end
      end
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = (c < 15);
        in_data[i*32 +: 32] = (c < 4) ? 32'(32'h100 + 16*i + c) : 32'hBAD0;
      end
      in_valid[2] = (c >= 10 && c < 14);
      in_data[64 +: 32] = (c >= 10 && c < 14) ? 32'(32'h120 + c - 10) : 32'hBAD2;
    end
    @(negedge clk);
    in_valid = 3'b000;
    for (int j = 0; j < 12; j++) begin
      exp = 32'(32'h100 + 16*(j/4) + j%4);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp) begin
        n_bad++; $display("[TB] FAIL stagger_data beat %0d: got v=%b d=%h expected v=1 d=%h", j, out_valid, out_data, exp);
      end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL stagger_end_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp;
    logic [3:0]  pat;
    int idx;
    pat = 4'b1001;
    idx = 0;
    fill_frame(32'h200);
    for (int cyc = 0; cyc < 200 && idx < 12; cyc++) begin
      out_ready = pat[cyc % 4];
      if (out_valid) begin
        exp = 32'(32'h200 + 16*(idx/4) + idx%4);
        n_cmp++; if (out_data !== exp) begin n_bad++; $display("[TB] FAIL bp_data idx %0d: got %h expected %h", idx, out_data, exp); end
        n_cmp++; if (out_src !== 2'(idx/4) || out_last !== (idx == 11)) begin
          n_bad++; $display("[TB] FAIL bp_src_last idx %0d: got s=%0d l=%b expected s=%0d l=%b", idx, out_src, out_last, idx/4, (idx == 11));
        end
        if (out_ready) idx++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_cmp++; if (idx !== 12) begin n_bad++; $display("[TB] FAIL bp_beat_count: got %0d expected 12", idx); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_end: got v=%b busy=%b expected v=0 busy=0", out_valid, busy); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    int idx;
    int cnt [3];
    idx = 0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    out_ready = 1'b1;
    fill_frame(32'h300);
    for (int cyc = 0; cyc < 80 && idx < 24; cyc++) begin
      if (busy) begin
        n_cmp++; if (in_ready !== 3'b000) begin n_bad++; $display("[TB] FAIL b2b_ready_in_drain cycle %0d: got %b expected 000", cyc, in_ready); end
      end
      if (out_valid) begin
        exp = 32'(((idx < 12) ? 32'h300 : 32'h400) + 16*((idx%12)/4) + idx%4);
        n_cmp++; if (out_data !== exp) begin n_bad++; $display("[TB] FAIL b2b_data idx %0d: got %h expected %h", idx, out_data, exp); end
        idx++;
      end
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = (cnt[i] < 4);
        in_data[i*32 +: 32] = 32'(32'h400 + 16*i + cnt[i]);
      end
      for (int i = 0; i < 3; i++) begin
        if (in_valid[i] && in_ready[i]) cnt[i]++;
      end
      @(negedge clk);
    end
    in_valid = 3'b000;
    n_cmp++; if (idx !== 24) begin n_bad++; $display("[TB] FAIL b2b_beat_count: got %0d expected 24", idx); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 3'b111) begin n_bad++; $display("[TB] FAIL b2b_end: got busy=%b rdy=%b expected busy=0 rdy=111", busy, in_ready); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp;
    int beats;
    beats = 0;
    out_ready = 1'b1;
    fill_frame(32'h500);
    for (int cyc = 0; cyc < 20 && beats < 5; cyc++) begin
      if (out_valid) begin
        exp = 32'(32'h500 + 16*(beats/4) + beats%4);
        n_cmp++; if (out_data !== exp) begin n_bad++; $display("[TB] FAIL rmid_pre_data beat %0d: got %h expected %h", beats, out_data, exp); end
        beats++;
      end
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("[TB] FAIL rmid_outputs: got v=%b l=%b busy=%b expected 0 0 0", out_valid, out_last, busy);
    end
    n_cmp++; if (in_ready !== 3'b111) begin n_bad++; $display("[TB] FAIL rmid_in_ready: got %b expected 111", in_ready); end
    n_cmp++; if (out_data !== 32'd0 || out_src !== 2'd0) begin n_bad++; $display("[TB] FAIL rmid_data_src: got d=%h s=%0d expected 0 0", out_data, out_src); end
    @(negedge clk);
    reset_n = 1'b1;
    fill_frame(32'h600);
    @(negedge clk);
    @(negedge clk);
    for (int j = 0; j < 12; j++) begin
      exp = 32'(32'h600 + 16*(j/4) + j%4);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp || out_src !== 2'(j/4)) begin
        n_bad++; $display("[TB] FAIL rmid_new_frame beat %0d: got v=%b d=%h s=%0d expected v=1 d=%h s=%0d", j, out_valid, out_data, out_src, exp, j/4);
      end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_end_valid: got %b expected 0", out_valid); end
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 3'b000;
    in_data    = '0;
    out_ready  = 1'b1;
    in_valid2  = 2'b00;
    in_data2   = '0;
    out_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] starting merge_ni tests");
    test_reset();
    test_fill();
    test_corner();
    test_staggered();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
